draw_bg_rects: RTL

//  Parametrised background renderer: border frame plus NUM_RECTS run-time-configurable coloured rectangles.

---
 rtl/draw_bg_rects_pkg.sv | 38 +++
 rtl/vga_if.sv | 13 +
 rtl/draw_bg_rects_hit.sv | 19 +
 rtl/draw_bg_rects.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/draw_bg_rects_pkg.sv
// Shared types and constants for the background renderer: rectangle record,
// screen geometry, commit FSM states and the power-up rectangle layout.
package draw_bg_rects_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
  localparam int RECT_W     = 57;
  localparam int MAX_RECTS  = 32;

  typedef struct packed {
    logic [10:0] x0;
    logic [10:0] y0;
    logic [10:0] x1;
    logic [10:0] y1;
    logic [11:0] rgb;
    logic        blink;
  } rect_t;

  typedef enum logic {
    IDLE,
    PENDING
  } commit_state_e;

  // x0 > x1 makes a slot unreachable, so unused slots can never paint a pixel.
  localparam rect_t EMPTY_RECT = '{11'd2047, 11'd0, 11'd0, 11'd0, 12'h000, 1'b0};

  localparam rect_t DEFAULT_RECTS [MAX_RECTS] = '{
    0: '{11'd32,  11'd32,  11'd991, 11'd47,  12'h888, 1'b0},
    1: '{11'd32,  11'd720, 11'd991, 11'd735, 12'h888, 1'b0},
    2: '{11'd32,  11'd48,  11'd47,  11'd719, 12'h888, 1'b0},
    3: '{11'd976, 11'd48,  11'd991, 11'd719, 12'h888, 1'b0},
    4: '{11'd300, 11'd300, 11'd363, 11'd363, 12'hf80, 1'b0},
    5: '{11'd600, 11'd200, 11'd631, 11'd500, 12'h0a0, 1'b0},
    6: '{11'd700, 11'd550, 11'd759, 11'd609, 12'hc0c, 1'b1},
    default: EMPTY_RECT
  };

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle passed between the stages of the video chain.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_bg_rects_hit.sv
// Combinational inclusive-bounds test of one pixel against one rectangle.
module rect_hit
  import draw_bg_rects_pkg::*;
(
  input  rect_t       rect,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic        hit
);

  logic unused_fields;

  assign unused_fields = ^{rect.rgb, rect.blink};

  // A degenerate rectangle (x0 > x1 or y0 > y1) fails one pair and never hits.
  assign hit = (rect.x0 <= hcount) && (hcount <= rect.x1) &&
               (rect.y0 <= vcount) && (vcount <= rect.y1);

endmodule

// File: rtl/draw_bg_rects.sv
// Background renderer: border frame plus double-buffered, optionally blinking
// rectangles, with a two-cycle pipeline from vga_in to vga_out.
module draw_bg_rects
  import draw_bg_rects_pkg::*;
#(
  parameter int          NUM_RECTS    = 16,
  parameter int          BORDER_W     = 1,
  parameter logic [11:0] BORDER_RGB   = 12'h00f,
  parameter logic [11:0] BG_RGB       = 12'h000,
  parameter int          BLINK_FRAMES = 32
) (
  input  logic              clk,
  input  logic              rst,
  vga_if.in                 vga_in,
  vga_if.out                vga_out,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [RECT_W-1:0] cfg_data,
  input  logic              cfg_commit,
  output logic              cfg_pending
);

  localparam int          CNT_W  = $clog2(BLINK_FRAMES);
  localparam logic [10:0] BW     = 11'(BORDER_W);
  localparam logic [10:0] H_EDGE = 11'(HOR_PIXELS - BORDER_W);
  localparam logic [10:0] V_EDGE = 11'(VER_PIXELS - BORDER_W);

  rect_t              shadow [NUM_RECTS];
  rect_t              active [NUM_RECTS];
  commit_state_e      state, state_nxt;
  logic               vblnk_rise, do_copy;
  logic [CNT_W-1:0]   frame_cnt;
  logic               blink_phase;
  logic [NUM_RECTS-1:0] hit, show;
  logic [11:0]        rect_rgb, pixel_rgb;
  logic               rect_any, border;
  logic               unused_rgb;

  logic [10:0] s1_hcount, s1_vcount;
  logic        s1_hsync, s1_vsync, s1_hblnk, s1_vblnk;
  logic        s1_border, s1_rect_any, s1_valid;
  logic [11:0] s1_rect_rgb;

  assign unused_rgb  = ^vga_in.rgb;
  assign vblnk_rise  = vga_in.vblnk && !s1_vblnk;
  assign do_copy     = vblnk_rise && ((state == PENDING) || cfg_commit);
  assign cfg_pending = (state == PENDING);

  for (genvar g = 0; g < NUM_RECTS; g++) begin : g_hit
    rect_hit u_hit (
      .rect   (active[g]),
      .hcount (vga_in.hcount),
      .vcount (vga_in.vcount),
      .hit    (hit[g])
    );
  end

  // Priority is resolved in S1 so each pixel sees one consistent bank and
  // blink phase, even on the edge where a commit or phase flip lands.
  always_comb begin
    show     = '0;
    rect_any = 1'b0;
    rect_rgb = 12'h000;
    for (int i = 0; i < NUM_RECTS; i++)
      show[i] = hit[i] && (!active[i].blink || !blink_phase);
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (show[i]) begin
        rect_any = 1'b1;
        rect_rgb = active[i].rgb;
      end
    end
  end

  assign border = (vga_in.hcount < BW) || (vga_in.hcount >= H_EDGE) ||
                  (vga_in.vcount < BW) || (vga_in.vcount >= V_EDGE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_commit && !vblnk_rise) state_nxt = PENDING;
      PENDING: if (vblnk_rise)                state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // The copy reads shadow before this cycle's write lands, so a write in the
  // copy cycle waits for the next commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        shadow[i] <= DEFAULT_RECTS[i];
        active[i] <= DEFAULT_RECTS[i];
      end
    end else begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        if (do_copy) active[i] <= shadow[i];
        if (cfg_we && (cfg_addr == 5'(i))) shadow[i] <= rect_t'(cfg_data);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (vblnk_rise) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_hcount   <= '0;
      s1_vcount   <= '0;
      s1_hsync    <= 1'b0;
      s1_vsync    <= 1'b0;
      s1_hblnk    <= 1'b0;
      s1_vblnk    <= 1'b0;
      s1_border   <= 1'b0;
      s1_rect_any <= 1'b0;
      s1_rect_rgb <= '0;
      s1_valid    <= 1'b0;
    end else begin
      s1_hcount   <= vga_in.hcount;
      s1_vcount   <= vga_in.vcount;
      s1_hsync    <= vga_in.hsync;
      s1_vsync    <= vga_in.vsync;
      s1_hblnk    <= vga_in.hblnk;
      s1_vblnk    <= vga_in.vblnk;
      s1_border   <= border;
      s1_rect_any <= rect_any;
      s1_rect_rgb <= rect_rgb;
      s1_valid    <= 1'b1;
    end
  end

  always_comb begin
    pixel_rgb = BG_RGB;
    if (!s1_valid || s1_hblnk || s1_vblnk) pixel_rgb = 12'h000;
    else if (s1_border)                    pixel_rgb = BORDER_RGB;
    else if (s1_rect_any)                  pixel_rgb = s1_rect_rgb;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= s1_hcount;
      vga_out.vcount <= s1_vcount;
      vga_out.hsync  <= s1_hsync;
      vga_out.vsync  <= s1_vsync;
      vga_out.hblnk  <= s1_hblnk;
      vga_out.vblnk  <= s1_vblnk;
      vga_out.rgb    <= pixel_rgb;
    end
  end

endmodule
